// File: rtl/writeback_unit.sv
// Writeback stage: commits retired ops to the register file, a register pair
// (16-bit mul/div) or data memory, and maintains the architectural zero flag.
module writeback_unit #(
    parameter logic [3:0] OP_MUL   = 4'b0101,
    parameter logic [3:0] OP_DIV   = 4'b0110,
    parameter logic [3:0] OP_STORE = 4'b1001,
    parameter logic [3:0] OP_NOP   = 4'b0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  opcode,
    input  logic [15:0] result,
    input  logic [7:0]  store_data,
    input  logic [2:0]  rd,
    input  logic [4:0]  mem_addr,
    output logic        reg_we,
    output logic [2:0]  reg_waddr,
    output logic [7:0]  reg_wdata,
    output logic        mem_we,
    output logic [4:0]  mem_waddr,
    output logic [7:0]  mem_wdata,
    output logic        flag_z,
    output logic        wb_done
);

    typedef enum logic [1:0] {IDLE, WR_LO, WR_HI, WR_MEM} state_t;

    state_t     state;
    logic [2:0] rd_q;
    logic [7:0] res_hi_q;
    logic       wide_q;
    logic       reg_we_q;
    logic       mem_we_q;
    logic       done_q;

    logic is_wide;
    assign is_wide  = (opcode == OP_MUL) || (opcode == OP_DIV);
    assign in_ready = enable && (state == IDLE);

    // Strobes are registered but masked by enable so a stall suppresses the
    // pending write; the held registers re-issue it once enable returns.
    assign reg_we  = reg_we_q && enable;
    assign mem_we  = mem_we_q && enable;
    assign wb_done = done_q   && enable;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            rd_q      <= '0;
            res_hi_q  <= '0;
            wide_q    <= 1'b0;
            reg_we_q  <= 1'b0;
            mem_we_q  <= 1'b0;
            done_q    <= 1'b0;
            reg_waddr <= '0;
            reg_wdata <= '0;
            mem_waddr <= '0;
            mem_wdata <= '0;
            flag_z    <= 1'b0;
        end else if (enable) begin
            reg_we_q  <= 1'b0;
            mem_we_q  <= 1'b0;
            done_q    <= 1'b0;
            reg_waddr <= '0;
            reg_wdata <= '0;
            mem_waddr <= '0;
            mem_wdata <= '0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        rd_q     <= rd;
                        res_hi_q <= result[15:8];
                        wide_q   <= is_wide;
                        if (opcode == OP_STORE) begin
                            state     <= WR_MEM;
                            mem_we_q  <= 1'b1;
                            mem_waddr <= mem_addr;
                            mem_wdata <= store_data;
                            done_q    <= 1'b1;
                        end else if (opcode == OP_NOP) begin
                            done_q <= 1'b1;
                        end else begin
                            state     <= WR_LO;
                            reg_we_q  <= 1'b1;
                            reg_waddr <= rd;
                            reg_wdata <= result[7:0];
                            done_q    <= !is_wide;
                            flag_z    <= is_wide ? (result == 16'h0000)
                                                 : (result[7:0] == 8'h00);
                        end
                    end
                end
                WR_LO: begin
                    if (wide_q) begin
                        state     <= WR_HI;
                        reg_we_q  <= 1'b1;
                        reg_waddr <= rd_q + 3'd1;
                        reg_wdata <= res_hi_q;
                        done_q    <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                WR_HI:   state <= IDLE;
                WR_MEM:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: directed spec cases plus random traffic
// with random stalls, checked against an op-level commit model.
module tb_writeback_unit;

    localparam logic [3:0] OP_MUL   = 4'b0101;
    localparam logic [3:0] OP_DIV   = 4'b0110;
    localparam logic [3:0] OP_STORE = 4'b1001;
    localparam logic [3:0] OP_NOP   = 4'b0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  opcode;
    logic [15:0] result;
    logic [7:0]  store_data;
    logic [2:0]  rd;
    logic [4:0]  mem_addr;
    logic        reg_we;
    logic [2:0]  reg_waddr;
    logic [7:0]  reg_wdata;
    logic        mem_we;
    logic [4:0]  mem_waddr;
    logic [7:0]  mem_wdata;
    logic        flag_z;
    logic        wb_done;

    writeback_unit dut (
        .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid),
        .in_ready(in_ready), .opcode(opcode), .result(result),
        .store_data(store_data), .rd(rd), .mem_addr(mem_addr),
        .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .flag_z(flag_z), .wb_done(wb_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // One observed commit cycle:
    // {reg_we, reg_waddr, reg_wdata, mem_we, mem_waddr, mem_wdata, wb_done, flag_z}
    typedef logic [27:0] ev_t;
    ev_t exp_q[$];

    // Model state: architectural zero flag and enabled cycles until idle.
    logic model_flag = 1'b0;
    int   busy       = 0;

    function automatic ev_t mk(input logic rwe, input logic [2:0] ra, input logic [7:0] rdat,
                               input logic mwe, input logic [4:0] ma, input logic [7:0] mdat,
                               input logic done, input logic fz);
        return {rwe, ra, rdat, mwe, ma, mdat, done, fz};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    // Expected commit cycles for one accepted op, in order.
    task automatic model_accept(input logic [3:0] op, input logic [15:0] res,
                                input logic [7:0] sd, input logic [2:0] r, input logic [4:0] ma);
        logic [2:0] r1;
        r1 = r + 3'd1;
        if (op == OP_STORE) begin
            exp_q.push_back(mk(0, 0, 0, 1, ma, sd, 1, model_flag));
            busy = 1;
        end else if (op == OP_NOP) begin
            exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 1, model_flag));
            busy = 0;
        end else if (op == OP_MUL || op == OP_DIV) begin
            model_flag = (res == 16'h0000);
            exp_q.push_back(mk(1, r, res[7:0], 0, 0, 0, 0, model_flag));
            exp_q.push_back(mk(1, r1, res[15:8], 0, 0, 0, 1, model_flag));
            busy = 2;
        end else begin
            model_flag = (res[7:0] == 8'h00);
            exp_q.push_back(mk(1, r, res[7:0], 0, 0, 0, 1, model_flag));
            busy = 1;
        end
    endtask

    // One clock of stimulus; returns whether the op is taken at the coming edge.
    task automatic cycle(input logic en, input logic vld, input logic [3:0] op,
                         input logic [15:0] res, input logic [7:0] sd,
                         input logic [2:0] r, input logic [4:0] ma, output logic taken);
        logic exp_ready;
        @(posedge clk);
        #1;
        enable = en; in_valid = vld; opcode = op; result = res;
        store_data = sd; rd = r; mem_addr = ma;
        #1;
        exp_ready = en && (busy == 0);
        check("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
        taken = vld && exp_ready;
        if (taken)
            model_accept(op, res, sd, r, ma);
        else if (en && busy > 0)
            busy--;
    endtask

    task automatic idle(input int n);
        logic t;
        for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 0, 0, 0, t);
    endtask

    task automatic send(input logic [3:0] op, input logic [15:0] res, input logic [7:0] sd,
                        input logic [2:0] r, input logic [4:0] ma);
        logic t;
        t = 1'b0;
        for (int i = 0; i < 10 && !t; i++) cycle(1, 1, op, res, sd, r, ma, t);
        if (!t) begin
            total++; bad++;
            $display("FAIL send_timeout got=not_accepted expected=accepted op=%h", op);
        end
    endtask

    // Monitor: every strobe/done cycle must match the next expected commit.
    always @(negedge clk) begin
        if (!reset && (reg_we || mem_we || wb_done)) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_commit got=%h expected=none",
                         mk(reg_we, reg_waddr, reg_wdata, mem_we, mem_waddr, mem_wdata, wb_done, flag_z));
            end else begin
                ev_t e, a;
                e = exp_q.pop_front();
                a = mk(reg_we, reg_waddr, reg_wdata, mem_we, mem_waddr, mem_wdata, wb_done, flag_z);
                if (a !== e) begin
                    bad++;
                    $display("FAIL commit got=%h expected=%h", a, e);
                end
            end
        end
    end

    initial begin
        logic t;
        reset = 1'b1; enable = 1'b1; in_valid = 1'b0; opcode = '0; result = '0;
        store_data = '0; rd = '0; mem_addr = '0;
        #2;
        check("reset_outputs",
              {4'd0, mk(reg_we, reg_waddr, reg_wdata, mem_we, mem_waddr, mem_wdata, wb_done, flag_z)}, 32'd0);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        #20;
        @(negedge clk);
        reset = 1'b0;

        // Directed cases
        send(4'b0001, 16'h003C, 8'h00, 3'd2, 5'd0);
        idle(2);
        send(OP_MUL, 16'h1234, 8'h00, 3'd7, 5'd0);
        idle(3);
        send(4'b0010, 16'h0100, 8'h00, 3'd1, 5'd0);
        idle(2);
        send(OP_STORE, 16'h0000, 8'hA5, 3'd0, 5'd31);
        idle(2);
        check("flag_after_store", {31'd0, flag_z}, 32'd1);
        send(OP_MUL, 16'h0100, 8'h00, 3'd3, 5'd0);
        idle(3);
        check("flag_after_mul", {31'd0, flag_z}, 32'd0);
        send(OP_NOP, 16'h0000, 8'h00, 3'd0, 5'd0);
        idle(2);

        // Stall during the high-byte write
        send(OP_DIV, 16'hBEEF, 8'h00, 3'd4, 5'd0);
        cycle(1, 0, 0, 0, 0, 0, 0, t);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0, 0, t);
        idle(3);

        // Reset in the low-byte write of a wide op
        send(OP_MUL, 16'hCAFE, 8'h00, 3'd5, 5'd0);
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("midop_reset_outputs",
              {4'd0, mk(reg_we, reg_waddr, reg_wdata, mem_we, mem_waddr, mem_wdata, wb_done, flag_z)}, 32'd0);
        exp_q.delete();
        model_flag = 1'b0;
        busy = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        send(4'b0011, 16'h0000, 8'h00, 3'd6, 5'd0);
        idle(3);

        // Random traffic with random stalls
        for (int i = 0; i < 600; i++) begin
            logic [3:0]  op;
            logic [15:0] res;
            int sel;
            sel = $urandom_range(0, 5);
            case (sel)
                0: op = OP_MUL;
                1: op = OP_DIV;
                2: op = OP_STORE;
                3: op = OP_NOP;
                default: op = 4'($urandom);
            endcase
            res = 16'($urandom);
            if ($urandom_range(0, 3) == 0) res[7:0] = 8'h00;
            if ($urandom_range(0, 7) == 0) res = 16'h0000;
            cycle(($urandom_range(0, 7) != 0), 1'($urandom), op, res,
                  8'($urandom), 3'($urandom), 5'($urandom), t);
        end
        idle(8);
        check("queue_drained", exp_q.size(), 32'd0);
        check("final_flag", {31'd0, flag_z}, {31'd0, model_flag});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
